// File: rtl/axi_shim_wide_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_shim_wide_pkg
// Description : Shared types, constants and helpers for axi_shim_wide.
//               Holds the write FSM state encoding, the AXI constants driven
//               on AW/AR, the response-decode helper and the width helpers
//               used to size the burst-length and outstanding-count fields.
//               Related compile-time option: AXI_SHIM_OT_LIMIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_shim_wide_pkg;

    // Write channel sequencing: which of AW / last-W is still outstanding.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        W_BOTH = 2'd1,
        W_DATA = 2'd2,
        W_ADDR = 2'd3
    } wr_state_e;

    localparam logic [1:0]  c_burst_incr       = 2'b01;
    localparam logic [3:0]  c_cache_modifiable = 4'b0010;
    localparam logic [1:0]  c_resp_exokay      = 2'b01;
    // ATOP bit that marks an atomic returning read data (R response).
    localparam int unsigned c_atop_r_resp      = 5;

    // Burst-length field width; at least one bit even for single-beat builds.
    function automatic int unsigned blen_w(input int unsigned num_words);
        return (num_words > 1) ? unsigned'($clog2(num_words)) : 1;
    endfunction

    // Counter width able to hold 0..max_ot inclusive.
    function automatic int unsigned cnt_w(input int unsigned max_ot);
        return unsigned'($clog2(max_ot + 1));
    endfunction

    // SLVERR (2'b10) and DECERR (2'b11) both have the MSB set.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_shim_wide_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_shim_wide_if
// Description : AXI4+ATOP master-port bundle used by axi_shim_wide.
//               master modport : shim side (drives AW/W/AR, B/R ready).
//               slave  modport : crossbar side (drives readys, B and R).
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_shim_wide_if #(
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned AxiIdWidth   = 4,
    parameter int unsigned AxiUserWidth = 1
);
    localparam int unsigned StrbW = AxiDataWidth / 8;

    logic                    aw_valid, aw_ready, aw_lock;
    logic [AxiIdWidth-1:0]   aw_id;
    logic [AxiAddrWidth-1:0] aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size, aw_prot;
    logic [1:0]              aw_burst;
    logic [3:0]              aw_cache, aw_qos, aw_region;
    logic [5:0]              aw_atop;
    logic [AxiUserWidth-1:0] aw_user;

    logic                    w_valid, w_ready, w_last;
    logic [AxiDataWidth-1:0] w_data;
    logic [StrbW-1:0]        w_strb;
    logic [AxiUserWidth-1:0] w_user;

    logic                    b_valid, b_ready;
    logic [AxiIdWidth-1:0]   b_id;
    logic [1:0]              b_resp;

    logic                    ar_valid, ar_ready, ar_lock;
    logic [AxiIdWidth-1:0]   ar_id;
    logic [AxiAddrWidth-1:0] ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size, ar_prot;
    logic [1:0]              ar_burst;
    logic [3:0]              ar_cache, ar_qos, ar_region;
    logic [AxiUserWidth-1:0] ar_user;

    logic                    r_valid, r_ready, r_last;
    logic [AxiIdWidth-1:0]   r_id;
    logic [AxiDataWidth-1:0] r_data;
    logic [1:0]              r_resp;
    logic [AxiUserWidth-1:0] r_user;

    modport master (
        output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
               aw_cache, aw_prot, aw_qos, aw_region, aw_atop, aw_user,
               w_valid, w_data, w_strb, w_last, w_user, b_ready,
               ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
               ar_cache, ar_prot, ar_qos, ar_region, ar_user, r_ready,
        input  aw_ready, w_ready, b_valid, b_id, b_resp,
               ar_ready, r_valid, r_id, r_data, r_resp, r_last, r_user
    );

    modport slave (
        input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
               aw_cache, aw_prot, aw_qos, aw_region, aw_atop, aw_user,
               w_valid, w_data, w_strb, w_last, w_user, b_ready,
               ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
               ar_cache, ar_prot, ar_qos, ar_region, ar_user, r_ready,
        output aw_ready, w_ready, b_valid, b_id, b_resp,
               ar_ready, r_valid, r_id, r_data, r_resp, r_last, r_user
    );

endinterface
`default_nettype wire

// File: rtl/axi_shim_ot_cnt.sv
`default_nettype none
// ============================================================================
// Module      : axi_shim_ot_cnt
// Description : Outstanding-transaction counter for one direction.
//               Ports: clk_i, rst_ni (async, active-low), inc_i (0..2
//               increments this cycle), dec_i, cnt_o, full_o (cnt==MaxCount),
//               empty_o (cnt==0). Leaving 0..MaxCount is an assertion error.
//               Instantiated by axi_shim_wide under AXI_SHIM_OT_LIMIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_shim_ot_cnt #(
    parameter int unsigned MaxCount = 4,
    parameter int unsigned CntW     = 3
) (
    input  wire logic            clk_i,
    input  wire logic            rst_ni,
    input  wire logic [1:0]      inc_i,
    input  wire logic            dec_i,
    output logic      [CntW-1:0] cnt_o,
    output logic                 full_o,
    output logic                 empty_o
);

    logic [CntW-1:0] cnt_q, cnt_d;
    // Two guard bits so that both overflow and underflow (wrap) land above
    // MaxCount and are caught by a single range check.
    logic [CntW+1:0] w_sum;

    assign w_sum   = {2'b00, cnt_q} + {{CntW{1'b0}}, inc_i} - {{(CntW+1){1'b0}}, dec_i};
    assign cnt_d   = w_sum[CntW-1:0];
    assign cnt_o   = cnt_q;
    assign full_o  = (cnt_q == CntW'(MaxCount));
    assign empty_o = (cnt_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    a_ot_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_sum <= (CntW+2)'(MaxCount));

endmodule
`default_nettype wire

// File: rtl/axi_shim_wide.sv
`default_nettype none
// ============================================================================
// Module      : axi_shim_wide
// Description : Converts cache/PTW/AMO read and write requests into AXI4+ATOP
//               transactions on one master port. AW and W are issued
//               independently; request payloads are not registered, so
//               requesters hold them until the grant. R and B pass straight
//               through with EXOKAY / error decode.
//               Ports: clk_i, rst_ni (async active-low); rd_* read request,
//               grant and R response; wr_* write request, grant and B
//               response; rd/wr_outstanding_o; axi (master modport).
//               Option AXI_SHIM_OT_LIMIT_EN: per-direction outstanding
//               counters that block new transactions at MaxOutstanding.
//               Without it the outstanding outputs are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_shim_wide
    import axi_shim_wide_pkg::*;
#(
    parameter int unsigned  AxiAddrWidth   = 64,
    parameter int unsigned  AxiDataWidth   = 64,
    parameter int unsigned  AxiIdWidth     = 4,
    parameter int unsigned  AxiUserWidth   = 1,
    parameter int unsigned  AxiNumWords    = 4,
    parameter int unsigned  MaxOutstanding = 4,
    localparam int unsigned BlenW          = blen_w(AxiNumWords),
    localparam int unsigned CntW           = cnt_w(MaxOutstanding),
    localparam int unsigned StrbW          = AxiDataWidth / 8
) (
    input  wire logic                                     clk_i,
    input  wire logic                                     rst_ni,
    // Read request / R response
    input  wire logic                                     rd_req_i,
    output logic                                          rd_gnt_o,
    input  wire logic [AxiAddrWidth-1:0]                  rd_addr_i,
    input  wire logic [BlenW-1:0]                         rd_blen_i,
    input  wire logic [2:0]                               rd_size_i,
    input  wire logic [AxiIdWidth-1:0]                    rd_id_i,
    input  wire logic                                     rd_lock_i,
    input  wire logic                                     rd_rdy_i,
    output logic                                          rd_valid_o,
    output logic                                          rd_last_o,
    output logic      [AxiDataWidth-1:0]                  rd_data_o,
    output logic      [AxiUserWidth-1:0]                  rd_user_o,
    output logic      [AxiIdWidth-1:0]                    rd_id_o,
    output logic                                          rd_exokay_o,
    output logic                                          rd_err_o,
    // Write request / B response
    input  wire logic                                     wr_req_i,
    output logic                                          wr_gnt_o,
    input  wire logic [AxiAddrWidth-1:0]                  wr_addr_i,
    input  wire logic [AxiNumWords-1:0][AxiDataWidth-1:0] wr_data_i,
    input  wire logic [AxiNumWords-1:0][AxiUserWidth-1:0] wr_user_i,
    input  wire logic [AxiNumWords-1:0][StrbW-1:0]        wr_be_i,
    input  wire logic [BlenW-1:0]                         wr_blen_i,
    input  wire logic [2:0]                               wr_size_i,
    input  wire logic [AxiIdWidth-1:0]                    wr_id_i,
    input  wire logic                                     wr_lock_i,
    input  wire logic [5:0]                               wr_atop_i,
    input  wire logic                                     wr_rdy_i,
    output logic                                          wr_valid_o,
    output logic      [AxiIdWidth-1:0]                    wr_id_o,
    output logic                                          wr_exokay_o,
    output logic                                          wr_err_o,
    // Outstanding counts
    output logic      [CntW-1:0]                          rd_outstanding_o,
    output logic      [CntW-1:0]                          wr_outstanding_o,
    // AXI master port
    axi_shim_wide_if.master                               axi
);

    // ------------------------------------------------------------------
    // Elaboration checks
    // ------------------------------------------------------------------
    if (AxiNumWords < 1) begin : g_chk_num_words
        $error("axi_shim_wide: AxiNumWords must be >= 1");
    end
    if ((AxiDataWidth < 32) || (AxiDataWidth > 512) ||
        ((AxiDataWidth & (AxiDataWidth - 1)) != 0)) begin : g_chk_data_width
        $error("axi_shim_wide: AxiDataWidth must be a power of two in 32..512");
    end
    if (AxiIdWidth < 2) begin : g_chk_id_width
        $error("axi_shim_wide: AxiIdWidth must be >= 2");
    end
    if (MaxOutstanding < 1) begin : g_chk_max_ot
        $error("axi_shim_wide: MaxOutstanding must be >= 1");
    end

    wr_state_e        wr_state_q, wr_state_d;
    logic [BlenW-1:0] wr_cnt_q, wr_cnt_d;

    logic w_wr_limit, w_rd_limit, w_wr_start;
    logic w_aw_vld, w_wch_vld, w_wch_last;
    logic w_aw_hs, w_wch_hs, w_wlast_hs, w_wr_gnt;
    logic w_ar_vld, w_ar_hs;

    // ------------------------------------------------------------------
    // Write channel sequencing
    // ------------------------------------------------------------------
    // The limit only gates leaving IDLE; once valids are up the FSM leaves
    // IDLE in the same cycle, so a started burst is never throttled.
    assign w_wr_start = wr_req_i & ~w_wr_limit;

    always_comb begin
        w_aw_vld  = 1'b0;
        w_wch_vld = 1'b0;
        case (wr_state_q)
            IDLE: begin
                w_aw_vld  = w_wr_start;
                w_wch_vld = w_wr_start;
            end
            W_BOTH: begin
                w_aw_vld  = 1'b1;
                w_wch_vld = 1'b1;
            end
            W_DATA:  w_wch_vld = 1'b1;
            W_ADDR:  w_aw_vld  = 1'b1;
            default: ;
        endcase
    end

    assign w_wch_last = (wr_cnt_q == wr_blen_i);
    assign w_aw_hs    = w_aw_vld & axi.aw_ready;
    assign w_wch_hs   = w_wch_vld & axi.w_ready;
    assign w_wlast_hs = w_wch_hs & w_wch_last;

    always_comb begin
        wr_state_d = wr_state_q;
        w_wr_gnt   = 1'b0;
        case (wr_state_q)
            IDLE, W_BOTH: begin
                // In IDLE, w_aw_vld is only high when a write is starting.
                if (w_aw_vld) begin
                    case ({w_aw_hs, w_wlast_hs})
                        2'b11: begin
                            wr_state_d = IDLE;
                            w_wr_gnt   = 1'b1;
                        end
                        2'b10:   wr_state_d = W_DATA;
                        2'b01:   wr_state_d = W_ADDR;
                        default: wr_state_d = W_BOTH;
                    endcase
                end
            end
            W_DATA: begin
                if (w_wlast_hs) begin
                    wr_state_d = IDLE;
                    w_wr_gnt   = 1'b1;
                end
            end
            W_ADDR: begin
                if (w_aw_hs) begin
                    wr_state_d = IDLE;
                    w_wr_gnt   = 1'b1;
                end
            end
            default: wr_state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (w_wr_gnt) begin
            wr_cnt_d = '0;
        end else if (w_wch_hs && !w_wch_last) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_state_q <= IDLE;
            wr_cnt_q   <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    assign wr_gnt_o = w_wr_gnt;

    // ------------------------------------------------------------------
    // Read address channel
    // ------------------------------------------------------------------
    assign w_ar_vld = rd_req_i & ~w_rd_limit;
    assign w_ar_hs  = w_ar_vld & axi.ar_ready;
    assign rd_gnt_o = w_ar_hs;

    // ------------------------------------------------------------------
    // Outstanding tracking
    // ------------------------------------------------------------------
`ifdef AXI_SHIM_OT_LIMIT_EN
    logic       w_wr_full, w_rd_full, w_wr_empty, w_rd_empty;
    logic       w_b_hs, w_r_last_hs;
    logic [1:0] w_rd_inc;

    assign w_b_hs      = axi.b_valid & wr_rdy_i;
    assign w_r_last_hs = axi.r_valid & axi.r_last & rd_rdy_i;
    // An atomic with read response also returns R data, so it occupies a
    // read slot; it can coincide with an AR handshake (two increments).
    assign w_rd_inc    = {1'b0, w_ar_hs} + {1'b0, w_wr_gnt & wr_atop_i[c_atop_r_resp]};

    assign w_wr_limit  = w_wr_full | (wr_atop_i[c_atop_r_resp] & w_rd_full);
    assign w_rd_limit  = w_rd_full;

    axi_shim_ot_cnt #(
        .MaxCount (MaxOutstanding),
        .CntW     (CntW)
    ) u_wr_ot_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   ({1'b0, w_wr_gnt}),
        .dec_i   (w_b_hs),
        .cnt_o   (wr_outstanding_o),
        .full_o  (w_wr_full),
        .empty_o (w_wr_empty)
    );

    axi_shim_ot_cnt #(
        .MaxCount (MaxOutstanding),
        .CntW     (CntW)
    ) u_rd_ot_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (w_rd_inc),
        .dec_i   (w_r_last_hs),
        .cnt_o   (rd_outstanding_o),
        .full_o  (w_rd_full),
        .empty_o (w_rd_empty)
    );

    a_b_needs_write : assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_b_hs |-> !w_wr_empty);
    a_r_needs_read : assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_r_last_hs |-> !w_rd_empty);
`else
    assign w_wr_limit       = 1'b0;
    assign w_rd_limit       = 1'b0;
    assign wr_outstanding_o = '0;
    assign rd_outstanding_o = '0;
`endif

    // ------------------------------------------------------------------
    // AXI request fields
    // ------------------------------------------------------------------
    assign axi.aw_valid  = w_aw_vld;
    assign axi.aw_id     = wr_id_i;
    assign axi.aw_addr   = wr_addr_i;
    assign axi.aw_len    = 8'(wr_blen_i);
    assign axi.aw_size   = wr_size_i;
    assign axi.aw_burst  = c_burst_incr;
    assign axi.aw_lock   = wr_lock_i;
    assign axi.aw_cache  = c_cache_modifiable;
    assign axi.aw_prot   = '0;
    assign axi.aw_qos    = '0;
    assign axi.aw_region = '0;
    assign axi.aw_atop   = wr_atop_i;
    assign axi.aw_user   = '0;

    assign axi.w_valid   = w_wch_vld;
    assign axi.w_data    = wr_data_i[wr_cnt_q];
    assign axi.w_strb    = wr_be_i[wr_cnt_q];
    assign axi.w_user    = wr_user_i[wr_cnt_q];
    assign axi.w_last    = w_wch_last;

    assign axi.ar_valid  = w_ar_vld;
    assign axi.ar_id     = rd_id_i;
    assign axi.ar_addr   = rd_addr_i;
    assign axi.ar_len    = 8'(rd_blen_i);
    assign axi.ar_size   = rd_size_i;
    assign axi.ar_burst  = c_burst_incr;
    assign axi.ar_lock   = rd_lock_i;
    assign axi.ar_cache  = c_cache_modifiable;
    assign axi.ar_prot   = '0;
    assign axi.ar_qos    = '0;
    assign axi.ar_region = '0;
    assign axi.ar_user   = '0;

    // ------------------------------------------------------------------
    // R / B passthrough
    // ------------------------------------------------------------------
    assign axi.r_ready   = rd_rdy_i;
    assign rd_valid_o    = axi.r_valid;
    assign rd_last_o     = axi.r_last;
    assign rd_data_o     = axi.r_data;
    assign rd_user_o     = axi.r_user;
    assign rd_id_o       = axi.r_id;
    assign rd_exokay_o   = (axi.r_resp == c_resp_exokay);
    assign rd_err_o      = resp_is_err(axi.r_resp);

    assign axi.b_ready   = wr_rdy_i;
    assign wr_valid_o    = axi.b_valid;
    assign wr_id_o       = axi.b_id;
    assign wr_exokay_o   = (axi.b_resp == c_resp_exokay);
    assign wr_err_o      = resp_is_err(axi.b_resp);

endmodule
`default_nettype wire
